multiplier_host: RTL and testbench

MULTIPLIER_HOST -- requirements
Module: multiplier_host

---
 rtl/multiplier_host.sv | 139 +++++++++++++
 tb/tb_multiplier_host.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multiplier_host.sv
// multiplier_host: drives one signed 12x12 multiply through an external bit-serial multiplier
// and collects the 24-bit product serially, with per-phase timeouts.
module multiplier_host (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] x_val,
  input  logic [11:0] y_val,
  output logic        busy,
  output logic [23:0] result,
  output logic        res_valid,
  output logic        err,
  output logic        x_in,
  output logic        y_in,
  output logic        sx,
  output logic        sy,
  input  logic        fx,
  input  logic        fy,
  output logic        mul,
  input  logic        done,
  output logic        sz,
  input  logic        z_out,
  input  logic        fz
);
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] SEND      = 4'd1;
  localparam logic [3:0] WAIT_F    = 4'd2;
  localparam logic [3:0] MUL       = 4'd3;
  localparam logic [3:0] WAIT_DONE = 4'd4;
  localparam logic [3:0] REQ_Z     = 4'd5;
  localparam logic [3:0] RECV      = 4'd6;
  localparam logic [3:0] FIN       = 4'd7;
  localparam logic [3:0] ERR       = 4'd8;
  logic [3:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bc_q, bc_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [23:0] z_q, z_d, result_q, result_d;
  logic        fx_seen_q, fx_seen_d, fy_seen_q, fy_seen_d;
  logic        err_q, err_d, res_valid_q, res_valid_d;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    bc_d        = bc_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    result_d    = result_q;
    fx_seen_d   = fx_seen_q;
    fy_seen_d   = fy_seen_q;
    err_d       = err_q;
    res_valid_d = state_q == FIN;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND;
          x_d       = x_val;
          y_d       = y_val;
          err_d     = 1'b0;
          fx_seen_d = 1'b0;
          fy_seen_d = 1'b0;
        end
      end
      SEND: begin
        x_d = {x_q[10:0], 1'b0};
        y_d = {y_q[10:0], 1'b0};
        if (cnt_q == 8'd11) begin
          state_d   = WAIT_F;
          fx_seen_d = fx_seen_q | fx;
          fy_seen_d = fy_seen_q | fy;
        end
      end
      WAIT_F: begin
        fx_seen_d = fx_seen_q | fx;
        fy_seen_d = fy_seen_q | fy;
        state_d   = (fx_seen_q && fy_seen_q) ? MUL : (cnt_q == 8'd15) ? ERR : WAIT_F;
      end
      MUL:       state_d = WAIT_DONE;
      WAIT_DONE: state_d = done ? REQ_Z : (cnt_q == 8'd254) ? ERR : WAIT_DONE;
      REQ_Z: begin
        state_d = RECV;
        bc_d    = 5'd0;
      end
      RECV: begin
        if (fz) begin
          z_d  = {z_q[22:0], z_out};
          bc_d = bc_q + 5'd1;
        end
        state_d = (fz && bc_q == 5'd23) ? FIN : (cnt_q == 8'd63) ? ERR : RECV;
      end
      FIN: begin
        result_d = z_q;
        state_d  = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // every state's cycle counter restarts from zero on entry
    if (state_d != state_q || state_q == IDLE) cnt_d = 8'd0;
    if (state_d == ERR) err_d = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bc_q        <= 5'd0;
      x_q         <= 12'd0;
      y_q         <= 12'd0;
      z_q         <= 24'd0;
      result_q    <= 24'd0;
      fx_seen_q   <= 1'b0;
      fy_seen_q   <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bc_q        <= bc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      result_q    <= result_d;
      fx_seen_q   <= fx_seen_d;
      fy_seen_q   <= fy_seen_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign sx        = state_q == SEND;
  assign sy        = state_q == SEND;
  assign x_in      = sx & x_q[11];
  assign y_in      = sy & y_q[11];
  assign mul       = state_q == MUL;
  assign sz        = state_q == REQ_Z;
  assign err       = err_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
endmodule

// File: tb/tb_multiplier_host.sv
// tb_multiplier_host: randomized bench with a behavioural serial-multiplier responder and product model.
module tb_multiplier_host;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [11:0] x_val = 12'd0, y_val = 12'd0;
  logic busy, res_valid, err, x_in, y_in, sx, sy, mul, sz;
  logic [23:0] result;
  logic fx, fy, done, z_out, fz;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;

  multiplier_host dut (
    .clk(clk), .rst(rst), .start(start), .x_val(x_val), .y_val(y_val),
    .busy(busy), .result(result), .res_valid(res_valid), .err(err),
    .x_in(x_in), .y_in(y_in), .sx(sx), .sy(sy), .fx(fx), .fy(fy),
    .mul(mul), .done(done), .sz(sz), .z_out(z_out), .fz(fz)
  );

  int f_delay = 2, d_delay = 5;
  bit fx_never = 0, fy_never = 0, done_never = 0, gap = 0;
  logic [11:0] xs, ys;
  logic [23:0] prod, last_res = 24'd0;
  int nb, fcd, dcd, zi, cyc;
  bit armed, streaming, sx_d;
  int rv_cnt = 0, mul_cnt = 0, sz_cnt = 0, leak_cnt = 0;

  // external multiplier model: deserialises operands, multiplies, streams product MSB first
  always @(negedge clk) begin
    if (rst) begin
      nb = 0; fcd = 0; dcd = 0; armed = 0; streaming = 0; sx_d = 0;
      fx = 0; fy = 0; done = 0; fz = 0; z_out = 0;
    end else begin
      if (res_valid) rv_cnt++;
      if (mul) mul_cnt++;
      if (sz) sz_cnt++;
      if ((!sx && (x_in || y_in)) || sx != sy) leak_cnt++;
      if (sx) begin
        if (!sx_d) begin nb = 0; armed = 0; streaming = 0; end
        xs = {xs[10:0], x_in};
        ys = {ys[10:0], y_in};
        nb++;
        fcd = f_delay;
      end else if (nb == 12 && fcd > 0) fcd--;
      sx_d = sx;
      fx = nb == 12 && fcd == 0 && !fx_never;
      fy = nb == 12 && fcd == 0 && !fy_never;
      if (mul) begin
        prod = $signed(xs) * $signed(ys);
        nb = 0; armed = 1; dcd = d_delay;
      end else if (armed && dcd > 0) dcd--;
      done = armed && dcd == 0 && !done_never;
      fz = 0; z_out = 0;
      if (streaming) begin
        cyc++;
        if (!(gap && cyc % 3 == 0)) begin
          fz = 1; z_out = prod[zi]; zi--;
          if (zi < 0) streaming = 0;
        end
      end
      if (sz) begin streaming = 1; armed = 0; done = 0; zi = 23; cyc = 0; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input string tag, input bit noise);
    int t = 0;
    while (busy && t < 700) begin
      if (noise) start = 1'($urandom % 2);
      step();
      t++;
    end
    if (noise) start = 1'b0;
    chk({tag, "_timeout"}, 32'(t < 700), 1);
  endtask

  task automatic run(input string tag, input logic [11:0] xv, input logic [11:0] yv, input bit hold, input bit noise);
    x_val = xv; y_val = yv; start = 1'b1;
    step();
    chk({tag, "_accept"}, busy, 1);
    if (!hold) start = 1'b0;
    wait_idle(tag, noise);
  endtask

  function automatic logic [23:0] ref_prod(input logic [11:0] a, input logic [11:0] b);
    int ia = $signed(a), ib = $signed(b);
    return 24'(ia * ib);
  endfunction

  task automatic txn(input string tag, input logic [11:0] xv, input logic [11:0] yv, input bit bad, input bit noise);
    int r0 = rv_cnt;
    run(tag, xv, yv, 1'b0, noise);
    if (!bad) begin
      last_res = ref_prod(xv, yv);
      chk({tag, "_result"}, result, last_res);
      chk({tag, "_xser"}, xs, xv);
      chk({tag, "_yser"}, ys, yv);
      chk({tag, "_rv"}, rv_cnt - r0, 1);
      chk({tag, "_err"}, err, 0);
    end else begin
      chk({tag, "_err"}, err, 1);
      chk({tag, "_held"}, result, last_res);
      chk({tag, "_rv"}, rv_cnt - r0, 0);
      chk({tag, "_busy"}, busy, 0);
    end
  endtask

  initial begin
    int m0, s0, r0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_ctl", {sx, sy, x_in, y_in, mul, sz}, 0);
    rst = 1'b0;
    step();
    txn("basic", 12'h003, 12'hFFE, 0, 0);
    chk("basic_const", result, 24'hFFFFFA);
    gap = 1; d_delay = 3;
    txn("minmin", 12'h800, 12'h800, 0, 0);
    chk("minmin_const", result, 24'h400000);
    for (int i = 0; i < 10; i++) begin
      f_delay = $urandom_range(0, 6);
      d_delay = $urandom_range(0, 40);
      gap = 1'($urandom % 2);
      txn($sformatf("rnd%0d", i), 12'($urandom), 12'($urandom), 0, 1);
    end
    f_delay = 2; d_delay = 5; gap = 0;
    fy_never = 1; m0 = mul_cnt;
    txn("nofy", 12'h123, 12'h456, 1, 0);
    chk("nofy_mul", mul_cnt - m0, 0);
    fy_never = 0;
    done_never = 1; s0 = sz_cnt;
    txn("nodone", 12'h7FF, 12'h002, 1, 0);
    chk("nodone_sz", sz_cnt - s0, 0);
    done_never = 0;
    txn("clr_err", 12'hFFF, 12'hFFF, 0, 0);
    x_val = 12'hABC; y_val = 12'h321; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("pre_rst_send", sx, 1);
    r0 = rv_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_ctl", {busy, res_valid, err, sx, sy, x_in, y_in, mul, sz}, 0);
    chk("midrst_result", result, 0);
    last_res = 24'd0;
    step(); step();
    rst = 1'b0;
    chk("midrst_rv", rv_cnt - r0, 0);
    txn("after_rst", 12'h001, 12'h001, 0, 0);
    m0 = mul_cnt; r0 = rv_cnt;
    run("hold", 12'h0F0, 12'hF0F, 1'b1, 1'b0);
    chk("hold_mul1", mul_cnt - m0, 1);
    chk("hold_rv1", rv_cnt - r0, 1);
    chk("hold_res1", result, ref_prod(12'h0F0, 12'hF0F));
    step();
    chk("hold_rearm", busy, 1);
    start = 1'b0;
    wait_idle("hold2", 1'b0);
    chk("hold_mul2", mul_cnt - m0, 2);
    chk("hold_rv2", rv_cnt - r0, 2);
    chk("hold_err", err, 0);
    chk("no_leak", leak_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
